// File: rtl/fft_frame_ctrl_pkg.sv
// fft_frame_ctrl_pkg: shared types, widths and config-word packing for the FFT frame controller
package fft_frame_ctrl_pkg;
  localparam int IN_AXI_WIDTH = 32;
  localparam int CFG_WIDTH = 16;
  localparam int CFG_FWD_INV_BIT = 0;
  localparam int CFG_SCALE_LSB = 1;
  localparam int CFG_SCALE_WIDTH = 12;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2
  } state_t;
  // Packs direction and scale schedule into the FFT config word; unused bits stay zero.
  function automatic logic [CFG_WIDTH-1:0] cfg_word(input logic fwd_inv, input logic [CFG_SCALE_WIDTH-1:0] scale_sch);
    logic [CFG_WIDTH-1:0] w;
    w = '0;
    w[CFG_FWD_INV_BIT] = fwd_inv;
    w[CFG_SCALE_LSB +: CFG_SCALE_WIDTH] = scale_sch;
    return w;
  endfunction
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: sample in/out streams, FFT config channel and FFT output monitor taps
interface fft_frame_ctrl_if;
  import fft_frame_ctrl_pkg::*;
  logic                    s_axis_tvalid;
  logic [IN_AXI_WIDTH-1:0] s_axis_tdata;
  logic                    s_axis_tready;
  logic                    m_axis_tvalid;
  logic [IN_AXI_WIDTH-1:0] m_axis_tdata;
  logic                    m_axis_tlast;
  logic                    m_axis_tready;
  logic                    m_cfg_tvalid;
  logic [CFG_WIDTH-1:0]    m_cfg_tdata;
  logic                    m_cfg_tready;
  logic                    fft_out_tvalid;
  logic                    fft_out_tready;
  logic                    fft_out_tlast;
  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready, m_cfg_tready,
           fft_out_tvalid, fft_out_tready, fft_out_tlast,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
           m_cfg_tvalid, m_cfg_tdata
  );
  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready, m_cfg_tready,
           fft_out_tvalid, fft_out_tready, fft_out_tlast,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast,
           m_cfg_tvalid, m_cfg_tdata
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames the windowed sample stream for the FFT, sends config, caps frames in flight
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int FFT_SIZE = 4096,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  fft_frame_ctrl_if.master           bus,
  input  logic                       evt_tlast_unexpected,
  input  logic                       evt_tlast_missing,
  input  logic                       enable,
  input  logic                       cfg_fwd_inv,
  input  logic [CFG_SCALE_WIDTH-1:0] cfg_scale_sch,
  input  logic                       cfg_update,
  input  logic                       err_clr,
  output logic [31:0]                frame_count,
  output logic [2:0]                 inflight,
  output logic [1:0]                 err_status,
  output logic                       busy
);
  localparam int CW = $clog2(FFT_SIZE);
  localparam logic [CW-1:0] LAST = CW'(FFT_SIZE - 1);
  localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);
  state_t                     state, next_state;
  logic [CW-1:0]              sample_cnt;
  logic                       cfg_pending;
  logic                       cfg_fwd_q;
  logic [CFG_SCALE_WIDTH-1:0] cfg_scale_q;
  logic                       gate, m_hs, tlast_hs, out_hs, cfg_hs, cfg_changed, cfg_enter;
  // Zero-latency stream gating: stalls only when a new frame would exceed the in-flight cap.
  always_comb begin
    gate = (state == STREAM) && !(sample_cnt == '0 && inflight == MAX_IF);
    bus.s_axis_tready = bus.m_axis_tready & gate;
    bus.m_axis_tvalid = bus.s_axis_tvalid & gate;
    bus.m_axis_tdata = bus.s_axis_tdata;
    bus.m_axis_tlast = sample_cnt == LAST;
    bus.m_cfg_tvalid = state == CONFIG;
    bus.m_cfg_tdata = cfg_word(cfg_fwd_q, cfg_scale_q);
    m_hs = bus.m_axis_tvalid & bus.m_axis_tready;
    tlast_hs = m_hs & bus.m_axis_tlast;
    out_hs = bus.fft_out_tvalid & bus.fft_out_tready & bus.fft_out_tlast;
    cfg_hs = bus.m_cfg_tvalid & bus.m_cfg_tready;
    cfg_changed = {cfg_fwd_inv, cfg_scale_sch} != {cfg_fwd_q, cfg_scale_q};
    busy = state != IDLE;
  end
  // Next-state: leave STREAM only on a tlast handshake, so frames are never truncated.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = enable ? CONFIG : IDLE;
      CONFIG:  next_state = cfg_hs ? STREAM : CONFIG;
      STREAM:  next_state = !tlast_hs ? STREAM : !enable ? IDLE : cfg_pending ? CONFIG : STREAM;
      default: next_state = IDLE;
    endcase
    cfg_enter = (next_state == CONFIG) && (state != CONFIG);
  end
  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  end
  // Config latch on CONFIG entry; pending flag re-arms on update or on any input change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_fwd_q <= 1'b0;
      cfg_scale_q <= '0;
      cfg_pending <= 1'b1;
    end else begin
      if (cfg_enter) begin
        cfg_fwd_q <= cfg_fwd_inv;
        cfg_scale_q <= cfg_scale_sch;
      end
      cfg_pending <= (cfg_update | cfg_changed) ? 1'b1 : cfg_hs ? 1'b0 : cfg_pending;
    end
  end
  // Sample position, frame counter and saturating in-flight frame count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      frame_count <= '0;
      inflight <= '0;
    end else begin
      if (m_hs) sample_cnt <= sample_cnt + 1'b1;
      if (tlast_hs) frame_count <= frame_count + 32'd1;
      if (tlast_hs && !out_hs && inflight != MAX_IF) inflight <= inflight + 3'd1;
      else if (!tlast_hs && out_hs && inflight != '0) inflight <= inflight - 3'd1;
    end
  end
  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_status <= '0;
    else err_status <= (err_clr ? 2'b00 : err_status) | {evt_tlast_missing, evt_tlast_unexpected};
  end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed checks of framing, config, in-flight cap, errors and reset
module tb_fft_frame_ctrl;
  import fft_frame_ctrl_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        evt_u, evt_m, enable, cfg_fwd_inv, cfg_update, err_clr;
  logic [11:0] cfg_scale_sch;
  logic [31:0] frame_count;
  logic [2:0]  inflight;
  logic [1:0]  err_status;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  fft_frame_ctrl_if bus();
  fft_frame_ctrl #(.FFT_SIZE(16), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .evt_tlast_unexpected(evt_u), .evt_tlast_missing(evt_m),
    .enable(enable), .cfg_fwd_inv(cfg_fwd_inv), .cfg_scale_sch(cfg_scale_sch),
    .cfg_update(cfg_update), .err_clr(err_clr),
    .frame_count(frame_count), .inflight(inflight), .err_status(err_status), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic idle_inputs;
    {evt_u, evt_m, enable, cfg_fwd_inv, cfg_update, err_clr} = '0;
    cfg_scale_sch = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.m_axis_tready = 1'b0;
    bus.m_cfg_tready = 1'b0;
    {bus.fft_out_tvalid, bus.fft_out_tready, bus.fft_out_tlast} = '0;
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic start_stream;
    enable = 1'b1;
    cfg_fwd_inv = 1'b1;
    cfg_scale_sch = 12'hAAA;
    bus.m_cfg_tready = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 1'b1;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || frame_count !== 32'd0 || inflight !== 3'd0 || err_status !== 2'b00)
      begin errors++; $display("FAIL reset_regs busy=%b fc=%0d infl=%0d err=%b required 0", busy, frame_count, inflight, err_status); end
    checks++;
    if (bus.m_cfg_tvalid !== 1'b0 || bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 1'b0 || bus.m_axis_tlast !== 1'b0)
      begin errors++; $display("FAIL reset_hs cfgv=%b mv=%b sr=%b tl=%b required 0", bus.m_cfg_tvalid, bus.m_axis_tvalid, bus.s_axis_tready, bus.m_axis_tlast); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_config_frame;
    int beats, ncfg;
    do_reset();
    start_stream();
    beats = 0;
    ncfg = 0;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      @(negedge clk);
      bus.s_axis_tdata = 32'h100 + beats;
      #1;
      if (bus.m_cfg_tvalid && bus.m_cfg_tready) begin
        ncfg++;
        checks++;
        if (bus.m_cfg_tdata !== 16'h1555) begin errors++; $display("FAIL cfg_word got %h required 1555", bus.m_cfg_tdata); end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beats++;
        checks++;
        if (bus.m_axis_tlast !== (beats == 16) || bus.m_axis_tdata !== 32'h100 + beats - 1)
          begin errors++; $display("FAIL frame1_beat%0d tlast=%b data=%h", beats, bus.m_axis_tlast, bus.m_axis_tdata); end
      end
    end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    #1;
    checks++;
    if (ncfg != 1 || beats != 16) begin errors++; $display("FAIL frame1_counts cfg=%0d beats=%0d required 1/16", ncfg, beats); end
    checks++;
    if (frame_count !== 32'd1 || inflight !== 3'd1) begin errors++; $display("FAIL frame1_regs fc=%0d infl=%0d required 1/1", frame_count, inflight); end
  endtask
  task automatic test_inflight_cap;
    int beats;
    do_reset();
    start_stream();
    beats = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus.s_axis_tdata = beats;
      #1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
    end
    checks++;
    if (beats != 32) begin errors++; $display("FAIL cap_beats got %0d required 32", beats); end
    checks++;
    if (bus.s_axis_tready !== 1'b0 || inflight !== 3'd2) begin errors++; $display("FAIL cap_stall sr=%b infl=%0d required 0/2", bus.s_axis_tready, inflight); end
    @(negedge clk);
    {bus.fft_out_tvalid, bus.fft_out_tready, bus.fft_out_tlast} = 3'b111;
    @(negedge clk);
    {bus.fft_out_tvalid, bus.fft_out_tready, bus.fft_out_tlast} = 3'b000;
    #1;
    checks++;
    if (inflight !== 3'd1 || bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL cap_release infl=%0d sr=%b required 1/1", inflight, bus.s_axis_tready); end
  endtask
  task automatic test_cfg_change;
    int beats, ncfg, cfg_at1;
    logic [15:0] cfg_dat1;
    do_reset();
    start_stream();
    beats = 0;
    ncfg = 0;
    cfg_at1 = -1;
    cfg_dat1 = '0;
    for (int c = 0; c < 60 && beats < 17; c++) begin
      @(negedge clk);
      #1;
      if (bus.m_cfg_tvalid && bus.m_cfg_tready) begin
        if (ncfg == 1) begin cfg_at1 = beats; cfg_dat1 = bus.m_cfg_tdata; end
        ncfg++;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beats++;
        if (beats == 5) cfg_scale_sch = 12'h555;
      end
    end
    checks++;
    if (ncfg != 2 || beats != 17) begin errors++; $display("FAIL cfgchg_counts cfg=%0d beats=%0d required 2/17", ncfg, beats); end
    checks++;
    if (cfg_at1 != 16 || cfg_dat1 !== 16'h0AAB) begin errors++; $display("FAIL cfgchg_resend at=%0d data=%h required 16/0aab", cfg_at1, cfg_dat1); end
  endtask
  task automatic test_enable_drop;
    int beats, extra;
    do_reset();
    start_stream();
    beats = 0;
    extra = 0;
    for (int c = 0; c < 40 && beats < 16; c++) begin
      @(negedge clk);
      #1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        beats++;
        checks++;
        if (bus.m_axis_tlast !== (beats == 16)) begin errors++; $display("FAIL drop_tlast beat%0d got %b", beats, bus.m_axis_tlast); end
        if (beats == 8) enable = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (beats != 16 || busy !== 1'b0 || frame_count !== 32'd1) begin errors++; $display("FAIL drop_idle beats=%0d busy=%b fc=%0d required 16/0/1", beats, busy, frame_count); end
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.m_axis_tvalid) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL drop_quiet got %0d beats required 0", extra); end
  endtask
  task automatic test_backpressure;
    int got;
    do_reset();
    start_stream();
    got = 0;
    for (int c = 0; c < 3000 && got < 160; c++) begin
      @(negedge clk);
      bus.s_axis_tvalid = 1'($urandom_range(0, 1));
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      bus.fft_out_tvalid = ($urandom_range(0, 3) == 0);
      bus.fft_out_tready = bus.fft_out_tvalid;
      bus.fft_out_tlast = bus.fft_out_tvalid;
      bus.s_axis_tdata = 32'hA000_0000 + got;
      #1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        checks++;
        if (bus.m_axis_tdata !== 32'hA000_0000 + got || bus.m_axis_tlast !== (got % 16 == 15))
          begin errors++; $display("FAIL bp_beat%0d data=%h tlast=%b", got, bus.m_axis_tdata, bus.m_axis_tlast); end
        got++;
      end
    end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    {bus.fft_out_tvalid, bus.fft_out_tready, bus.fft_out_tlast} = 3'b000;
    #1;
    checks++;
    if (got != 160 || frame_count !== 32'd10) begin errors++; $display("FAIL bp_total beats=%0d fc=%0d required 160/10", got, frame_count); end
  endtask
  task automatic test_errors_reset;
    int beats;
    do_reset();
    @(negedge clk);
    evt_m = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    evt_m = 1'b0;
    err_clr = 1'b0;
    #1;
    checks++;
    if (err_status !== 2'b10) begin errors++; $display("FAIL err_set_wins got %b required 10", err_status); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checks++;
    if (err_status !== 2'b00) begin errors++; $display("FAIL err_clear got %b required 00", err_status); end
    @(negedge clk);
    evt_u = 1'b1;
    @(negedge clk);
    evt_u = 1'b0;
    #1;
    checks++;
    if (err_status !== 2'b01) begin errors++; $display("FAIL err_unexp got %b required 01", err_status); end
    start_stream();
    beats = 0;
    for (int c = 0; c < 60 && beats < 23; c++) begin
      @(negedge clk);
      #1;
      if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
    end
    checks++;
    if (beats != 23 || frame_count !== 32'd1 || !busy) begin errors++; $display("FAIL pre_reset beats=%0d fc=%0d busy=%b required 23/1/1", beats, frame_count, busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || frame_count !== 32'd0 || inflight !== 3'd0 || err_status !== 2'b00)
      begin errors++; $display("FAIL midreset_regs busy=%b fc=%0d infl=%0d err=%b required 0", busy, frame_count, inflight, err_status); end
    checks++;
    if (bus.m_cfg_tvalid !== 1'b0 || bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 1'b0 || bus.m_axis_tlast !== 1'b0)
      begin errors++; $display("FAIL midreset_hs cfgv=%b mv=%b sr=%b tl=%b required 0", bus.m_cfg_tvalid, bus.m_axis_tvalid, bus.s_axis_tready, bus.m_axis_tlast); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_config_frame();
    test_inflight_cap();
    test_cfg_change();
    test_enable_drop();
    test_backpressure();
    test_errors_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
